// File: rtl/rda_pipe_adder.sv
// rda_pipe_adder: pipelined recursive-doubling (kill/propagate/generate) adder/subtractor.
// An entry stage forms per-bit KPG codes, LOG2W registered doubling levels resolve every
// code to kill or generate, and a final stage forms sum, carry, overflow and zero flags.
// The whole pipe moves together and freezes while a finished result waits downstream.
module rda_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W = $clog2(WIDTH);
  // Stage 0 is the entry stage, stages 1..LOG2W are the doubling levels.
  localparam int NSTG  = LOG2W + 1;

  typedef logic [WIDTH-1:0][1:0] codeVec_t;

  logic             advance;
  logic [WIDTH-1:0] bPrime;
  logic             carryIn;

  logic [NSTG-1:0]  valid_q, valid_d;
  logic [NSTG-1:0]  slot_q, slot_d;
  codeVec_t         code_q [NSTG];
  codeVec_t         code_d [NSTG];
  logic [WIDTH-1:0] halfSum_q [NSTG];
  logic [WIDTH-1:0] halfSum_d [NSTG];
  logic [TAG_W-1:0] tag_q [NSTG];
  logic [TAG_W-1:0] tag_d [NSTG];

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Next state of the entry stage and of every doubling level.
  always_comb begin
    bPrime  = sub ? ~b : b;
    carryIn = sub | cin;

    valid_d[0]   = in_valid;
    slot_d[0]    = carryIn;
    halfSum_d[0] = a ^ bPrime;
    tag_d[0]     = in_tag;
    for (int i = 0; i < WIDTH; i++) begin
      code_d[0][i] = {a[i], bPrime[i]};
    end
    // Bit 0 is resolved against the carry-in slot here, so LOG2W levels are enough
    // to carry a resolved code all the way to the MSB.
    if (a[0] ^ bPrime[0]) begin
      code_d[0][0] = {2{carryIn}};
    end

    for (int s = 1; s < NSTG; s++) begin
      valid_d[s]   = valid_q[s-1];
      slot_d[s]    = slot_q[s-1];
      halfSum_d[s] = halfSum_q[s-1];
      tag_d[s]     = tag_q[s-1];
      code_d[s]    = code_q[s-1];
      for (int i = (1 << (s - 1)); i < WIDTH; i++) begin
        if (code_q[s-1][i][1] != code_q[s-1][i][0]) begin
          code_d[s][i] = code_q[s-1][i - (1 << (s - 1))];
        end
      end
    end
  end

  // Pipeline registers: cleared on reset, shift together only when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      slot_q  <= '0;
      for (int s = 0; s < NSTG; s++) begin
        code_q[s]    <= '0;
        halfSum_q[s] <= '0;
        tag_q[s]     <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      for (int s = 0; s < NSTG; s++) begin
        code_q[s]    <= code_d[s];
        halfSum_q[s] <= halfSum_d[s];
        tag_q[s]     <= tag_d[s];
      end
    end
  end

  // Final stage: carries come from the resolved codes, then sum and flags.
  always_comb begin
    carry[0] = slot_q[NSTG-1];
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = code_q[NSTG-1][i-1][1];
    end
    sum_d  = halfSum_q[NSTG-1] ^ carry;
    cout_d = code_q[NSTG-1][WIDTH-1][1];
    ovf_d  = carry[WIDTH-1] ^ cout_d;
    zero_d = ~|sum_d;
  end

  // Output registers: load a new result when the pipe advances, hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= valid_q[NSTG-1];
      if (valid_q[NSTG-1]) begin
        sum     <= sum_d;
        cout    <= cout_d;
        ovf     <= ovf_d;
        zero    <= zero_d;
        out_tag <= tag_q[NSTG-1];
      end
    end
  end

endmodule

// File: tb/tb_rda_pipe_adder.sv
// tb_rda_pipe_adder: scoreboard bench for rda_pipe_adder at WIDTH=8.
// Stimulus pushes hand-computed results into a queue; a monitor pops and compares
// each result the DUT hands over, including tag order and the 5-cycle latency.
module tb_rda_pipe_adder;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int LATENCY = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag;
    int               acceptCycle;
    bit               checkLat;
  } expect_t;

  expect_t sbq[$];
  expect_t monExp;
  int      checks = 0;
  int      errors = 0;
  int      cycle  = 0;

  rda_pipe_adder #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .out_tag  (out_tag)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time results against their acceptance.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Present one op and wait (bounded) until it is accepted; optionally record its expected result.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cinv,
                               input logic subv, input logic [3:0] tagv,
                               input logic [7:0] eSum, input logic eCout, input logic eOvf,
                               input logic eZero, input bit push, input bit lat);
    expect_t item;
    bit      accepted;
    int      n;
    a        = av;
    b        = bv;
    cin      = cinv;
    sub      = subv;
    in_tag   = tagv;
    in_valid = 1'b1;
    accepted = 1'b0;
    n        = 0;
    while (!accepted && n < 50) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual=no accept required=accept for tag %0h", tagv);
    end else if (push) begin
      item.sum         = eSum;
      item.cout        = eCout;
      item.ovf         = eOvf;
      item.zero        = eZero;
      item.tag         = tagv;
      item.acceptCycle = cycle;
      item.checkLat    = lat;
      sbq.push_back(item);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_queue_empty", sbq.size(), 0);
  endtask

  function automatic expect_t modelOp(input logic [7:0] av, input logic [7:0] bv,
                                      input logic cinv, input logic subv);
    expect_t r;
    logic [8:0] full;
    if (subv) full = {1'b0, av} - {1'b0, bv} + 9'h100;
    else      full = {1'b0, av} + {1'b0, bv} + {8'h00, cinv};
    r.sum  = full[7:0];
    r.cout = full[8];
    if (subv) r.ovf = (av[7] != bv[7]) && (r.sum[7] != av[7]);
    else      r.ovf = (av[7] == bv[7]) && (r.sum[7] != av[7]);
    r.zero = (r.sum == 8'h00);
    r.tag  = '0;
    r.acceptCycle = 0;
    r.checkLat    = 1'b0;
    return r;
  endfunction

  // Monitor: every handed-over result is compared against the front of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: actual=tag %0h sum %0h required=no result", out_tag, sum);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("sum", sum, monExp.sum);
        checkOutput("cout", cout, monExp.cout);
        checkOutput("ovf", ovf, monExp.ovf);
        checkOutput("zero", zero, monExp.zero);
        checkOutput("out_tag", out_tag, monExp.tag);
        if (monExp.checkLat) checkOutput("latency", cycle - monExp.acceptCycle, LATENCY);
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Main stimulus sequence.
  initial begin
    expect_t m;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       rs;
    int         ghosts;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_zero", zero, 0);
    checkOutput("reset_out_tag", out_tag, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single ops");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 4'h2, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 4'h3, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    applyStimulus(8'h7F, 8'h00, 1'b1, 1'b0, 4'h4, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] back-to-back ops");
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 4'h0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h10, 8'h20, 1'b1, 1'b0, 4'h1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h64, 8'h64, 1'b0, 1'b1, 4'h2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'hC8, 8'hC8, 1'b0, 1'b0, 4'h3, 8'h90, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b1, 4'h4, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 4'h5, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(8'h11, 8'h22, 1'b0, 1'b0, 4'h8, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA0, 8'h70, 1'b0, 1'b0, 4'h9, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h40, 8'h40, 1'b0, 1'b0, 4'hA, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, 4'hB, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h55, 8'hAA, 1'b1, 1'b0, 4'hC, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    a        = 8'h0F;
    b        = 8'hF0;
    cin      = 1'b0;
    sub      = 1'b0;
    in_tag   = 4'hD;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_sum", sum, sbq[0].sum);
      checkOutput("stall_out_tag", out_tag, sbq[0].tag);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'h0F, 8'hF0, 1'b0, 1'b0, 4'hD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] mixed ops with bubbles");
    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      m  = modelOp(ra, rb, rc, rs);
      applyStimulus(ra, rb, rc, rs, 4'(k), m.sum, m.cout, m.ovf, m.zero, 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    waitDrain();

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    applyStimulus(8'h21, 8'h12, 1'b0, 1'b0, 4'h6, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 4'h7, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h02, 8'h02, 1'b0, 1'b0, 4'h8, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h03, 1'b0, 1'b0, 4'h9, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    checkOutput("pre_reset_out_valid", out_valid, 1);
    checkOutput("pre_reset_sum", sum, 8'h33);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", out_valid, 0);
    checkOutput("mid_reset_sum", sum, 0);
    checkOutput("mid_reset_out_tag", out_tag, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ghosts = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    checkOutput("ghost_results", ghosts, 0);
    @(posedge clk);
    #1;
    applyStimulus(8'h7F, 8'h00, 1'b1, 1'b0, 4'hE, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
